// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of an asynchronous
// square wave in local clock cycles, flags loss of signal and reports lock.
module clock_period_meter #(
  parameter int unsigned      CNT_W      = 28,
  parameter logic [CNT_W-1:0] TIMEOUT    = 28'd50_000_000,
  parameter logic [CNT_W-1:0] TOLERANCE  = 28'd1,
  parameter int unsigned      LOCK_COUNT = 4
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  localparam int unsigned      SC_W    = 4;
  localparam logic [SC_W-1:0]  LOCK_C  = SC_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOW  = 2'd1,
    S_WAIT_EDGE = 2'd2,
    S_MEASURE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sync1;
  logic             r_s;
  logic             r_p;
  logic             w_rise;
  logic             w_fall;

  logic             r_flush;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_hlat;
  logic [CNT_W-1:0] r_prev;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [SC_W-1:0]  r_stable;
  logic             r_valid;
  logic             r_timeout;
  logic             r_locked;

  logic             w_flush_nxt;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic [CNT_W-1:0] w_hlat_nxt;
  logic [CNT_W-1:0] w_prev_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] w_high_nxt;
  logic [SC_W-1:0]  w_stable_nxt;
  logic             w_valid_nxt;
  logic             w_timeout_nxt;
  logic             w_locked_nxt;

  logic [CNT_W-1:0] w_pcnt_inc;
  logic [CNT_W-1:0] w_diff;
  logic [SC_W-1:0]  w_stable_meas;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
      r_p     <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_s     <= r_sync1;
      r_p     <= r_s;
    end
  end

  assign w_rise = r_s & ~r_p;
  assign w_fall = ~r_s & r_p;

  // Measured period candidate, its distance to the previous one, and new stable count
  always_comb begin
    w_pcnt_inc = r_pcnt + CNT_W'(1);
    w_diff     = (w_pcnt_inc >= r_prev) ? (w_pcnt_inc - r_prev) : (r_prev - w_pcnt_inc);
    if (w_diff <= TOLERANCE) begin
      w_stable_meas = (r_stable >= LOCK_C) ? LOCK_C : (r_stable + SC_W'(1));
    end else begin
      w_stable_meas = SC_W'(1);
    end
  end

  // Next-state and datapath update; enable low overrides every state
  always_comb begin
    w_state_nxt   = r_state;
    w_flush_nxt   = r_flush;
    w_pcnt_nxt    = r_pcnt;
    w_hlat_nxt    = r_hlat;
    w_prev_nxt    = r_prev;
    w_period_nxt  = r_period;
    w_high_nxt    = r_high;
    w_stable_nxt  = r_stable;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;
    w_locked_nxt  = r_locked;

    if (!enable) begin
      w_state_nxt   = S_IDLE;
      w_flush_nxt   = 1'b0;
      w_pcnt_nxt    = '0;
      w_stable_nxt  = '0;
      w_locked_nxt  = 1'b0;
      w_timeout_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // two cycles let the synchronizer flush stale samples
          if (r_flush) begin
            w_flush_nxt = 1'b0;
            w_state_nxt = S_WAIT_LOW;
          end else begin
            w_flush_nxt = 1'b1;
          end
        end
        S_WAIT_LOW: begin
          w_pcnt_nxt = '0;
          if (!r_s) begin
            w_state_nxt = S_WAIT_EDGE;
          end
        end
        S_WAIT_EDGE: begin
          if (w_rise) begin
            w_pcnt_nxt  = '0;
            w_state_nxt = S_MEASURE;
          end else if (r_pcnt >= TO_LAST) begin
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
            w_stable_nxt  = '0;
            w_pcnt_nxt    = '0;
            w_state_nxt   = S_WAIT_LOW;
          end else begin
            w_pcnt_nxt = w_pcnt_inc;
          end
        end
        S_MEASURE: begin
          if (w_rise) begin
            // a rise always wins over a coincident timeout
            w_period_nxt  = w_pcnt_inc;
            w_high_nxt    = r_hlat;
            w_valid_nxt   = 1'b1;
            w_pcnt_nxt    = '0;
            w_timeout_nxt = 1'b0;
            w_prev_nxt    = w_pcnt_inc;
            w_stable_nxt  = w_stable_meas;
            w_locked_nxt  = (w_stable_meas >= LOCK_C);
          end else begin
            if (w_fall) begin
              w_hlat_nxt = w_pcnt_inc;
            end
            if (r_pcnt >= TO_LAST) begin
              w_timeout_nxt = 1'b1;
              w_locked_nxt  = 1'b0;
              w_stable_nxt  = '0;
              w_pcnt_nxt    = '0;
              w_state_nxt   = S_WAIT_LOW;
            end else begin
              w_pcnt_nxt = w_pcnt_inc;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters and registered outputs
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_flush   <= 1'b0;
      r_pcnt    <= '0;
      r_hlat    <= '0;
      r_prev    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_stable  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_flush   <= w_flush_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_hlat    <= w_hlat_nxt;
      r_prev    <= w_prev_nxt;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_stable  <= w_stable_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_locked  <= w_locked_nxt;
    end
  end

  assign period_out = r_period;
  assign high_out   = r_high;
  assign valid      = r_valid;
  assign timeout    = r_timeout;
  assign locked     = r_locked;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: scoreboard bench for clock_period_meter.
module tb_clock_period_meter;

  localparam int unsigned CNT_W = 28;

  logic             clock_in;
  logic             reset_n;
  logic             sig_in;
  logic             enable;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             timeout;
  logic             locked;

  clock_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (28'd100),
    .TOLERANCE  (28'd1),
    .LOCK_COUNT (4)
  ) u_dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .enable     (enable),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .timeout    (timeout),
    .locked     (locked)
  );

  typedef struct {
    int unsigned period;
    int unsigned high;
    bit          lck;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_async  = 0;
  bit          async_mode = 1'b0;
  bit          armed = 1'b0;
  bit          pend_ok = 1'b0;
  int unsigned pend_p = 0;
  int unsigned pend_h = 0;
  int unsigned m_stable = 0;
  int unsigned m_prev = 0;
  int unsigned last_p = 0;

  initial begin
    clock_in = 1'b0;
    forever #50 clock_in = ~clock_in;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: stable count and lock for one completed period
  task automatic sb_push(input int unsigned p, input int unsigned h);
    int unsigned d;
    exp_t x;
    d = (p > m_prev) ? (p - m_prev) : (m_prev - p);
    if (m_stable != 0 && d <= 1) m_stable = (m_stable >= 4) ? 4 : m_stable + 1;
    else m_stable = 1;
    m_prev   = p;
    x.period = p;
    x.high   = h;
    x.lck    = (m_stable >= 4);
    sb_q.push_back(x);
  endtask

  task automatic sb_restart();
    armed    = 1'b1;
    pend_ok  = 1'b0;
    m_stable = 0;
    m_prev   = 0;
  endtask

  task automatic disarm();
    armed   = 1'b0;
    pend_ok = 1'b0;
  endtask

  // A rising edge closes the pending period, whose result is then expected
  task automatic rise(input int unsigned h, input int unsigned l);
    sig_in = 1'b1;
    if (armed) begin
      if (pend_ok) sb_push(pend_p, pend_h);
      pend_p  = h + l;
      pend_h  = h;
      pend_ok = 1'b1;
    end
  endtask

  task automatic gen_period(input int unsigned h, input int unsigned l);
    rise(h, l);
    repeat (h) @(negedge clock_in);
    sig_in = 1'b0;
    repeat (l) @(negedge clock_in);
  endtask

  task automatic rearm();
    disarm();
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clock_in);
    enable = 1'b1;
    repeat (8) @(negedge clock_in);
    sb_restart();
  endtask

  // Output monitor: pops one expectation per valid pulse
  always @(negedge clock_in) begin
    if (valid) begin
      chk("valid_timeout", 32'(timeout), 0);
      if (async_mode) begin
        n_async++;
        chk("async_period", 32'(period_out == 13 || period_out == 14), 1);
        chk("async_high", 32'(high_out == 6 || high_out == 7), 1);
      end else if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 0);
      end else begin
        e = sb_q.pop_front();
        chk("period", 32'(period_out), e.period);
        chk("high", 32'(high_out), e.high);
        chk("locked_at_valid", 32'(locked), 32'(e.lck));
        last_p = e.period;
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    repeat (3) @(negedge clock_in);
    chk("rst_period", 32'(period_out), 0);
    chk("rst_high", 32'(high_out), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_locked", 32'(locked), 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (6) @(negedge clock_in);

    // Synchronous clock_in/5 source, then loss of signal
    sb_restart();
    for (int i = 0; i < 8; i++) gen_period(2, 3);
    chk("div5_drain", sb_q.size(), 0);
    chk("div5_locked", 32'(locked), 1);
    repeat (97) @(negedge clock_in);
    chk("to_early_timeout", 32'(timeout), 0);
    chk("to_early_locked", 32'(locked), 1);
    @(negedge clock_in);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_locked", 32'(locked), 0);
    chk("to_period_hold", 32'(period_out), 5);
    chk("to_high_hold", 32'(high_out), 2);

    // Restart after loss of signal; first new valid clears timeout
    sb_restart();
    gen_period(2, 3);
    chk("to_still_set", 32'(timeout), 1);
    for (int i = 0; i < 3; i++) gen_period(2, 3);
    chk("to_cleared", 32'(timeout), 0);
    chk("restart_drain", sb_q.size(), 0);

    // Reset mid-measurement with sig_in held high through release
    disarm();
    sig_in  = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clock_in);
    chk("rst2_period", 32'(period_out), 0);
    chk("rst2_locked", 32'(locked), 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clock_in);
    chk("high_start_no_valid", 32'(valid), 0);
    sig_in = 1'b0;
    repeat (5) @(negedge clock_in);
    sb_restart();
    for (int i = 0; i < 4; i++) gen_period(5, 5);
    chk("high_start_drain", sb_q.size(), 0);
    chk("high_start_period", 32'(period_out), 10);

    // Alternating 8/12 never locks
    rearm();
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) gen_period(4, 4);
      else gen_period(6, 6);
    end
    chk("alt_drain", sb_q.size(), 0);
    chk("alt_not_locked", 32'(locked), 0);

    // Alternating 8/9 locks after four measurements
    rearm();
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) gen_period(4, 4);
      else gen_period(4, 5);
    end
    chk("tol_drain", sb_q.size(), 0);
    chk("tol_locked", 32'(locked), 1);

    // Enable dropped mid-period, then restored
    rearm();
    for (int i = 0; i < 3; i++) gen_period(5, 5);
    rise(5, 5);
    repeat (5) @(negedge clock_in);
    enable = 1'b0;
    disarm();
    repeat (2) @(negedge clock_in);
    chk("dis_locked", 32'(locked), 0);
    chk("dis_timeout", 32'(timeout), 0);
    sig_in = 1'b0;
    repeat (3) @(negedge clock_in);
    for (int i = 0; i < 2; i++) gen_period(5, 5);
    chk("dis_period_hold", 32'(period_out), last_p);
    chk("dis_high_hold", 32'(high_out), 5);
    enable = 1'b1;
    repeat (8) @(negedge clock_in);
    sb_restart();
    gen_period(5, 5);
    rise(5, 5);
    repeat (2) @(negedge clock_in);
    chk("valid_early", 32'(valid), 0);
    @(negedge clock_in);
    chk("valid_latency", 32'(valid), 1);
    repeat (2) @(negedge clock_in);
    sig_in = 1'b0;
    repeat (5) @(negedge clock_in);
    gen_period(5, 5);
    chk("reen_drain", sb_q.size(), 0);

    // Asynchronous source, period 13.3 local cycles
    rearm();
    disarm();
    async_mode = 1'b1;
    @(negedge clock_in);
    #3;
    for (int i = 0; i < 60; i++) begin
      sig_in = ~sig_in;
      #665;
    end
    sig_in = 1'b0;
    repeat (5) @(negedge clock_in);
    chk("async_locked", 32'(locked), 1);
    chk("async_count", 32'(n_async >= 25), 1);
    async_mode = 1'b0;
    repeat (5) @(negedge clock_in);
    chk("final_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
